updown_sweep_ctrl: RTL and testbench

Controller plus embedded N-bit up/down counter that runs programmed triangle sweeps between a low and a high bound. Optional dwell at each turnaround; a fixed number of round trips per command. It sequences the counter datapath for pattern/stimulus generation. Uses a start/busy/done handshake toward the requesting logic.

---
 rtl/updown_sweep_ctrl.sv | 165 ++++++++++++++++
 tb/tb_updown_sweep_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: triangle-sweep controller with an embedded up/down counter.
// The counter ramps from a latched low bound to a latched high bound and back,
// optionally dwelling at each turnaround, for a programmed number of round trips.
// Handshake: start (sampled in IDLE) / busy / done, with err on a rejected start.
// Optional build macro SWEEP_ABORT_EN adds an abort input that returns a busy
// sweep to IDLE without pulsing done.
module updown_sweep_ctrl #(
    parameter int N  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef SWEEP_ABORT_EN
    input  logic          abort,
`endif
    input  logic [N-1:0]  lo,
    input  logic [N-1:0]  hi,
    input  logic [CW-1:0] cycles,
    input  logic [CW-1:0] dwell,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          up_or_down,
    output logic [N-1:0]  count,
    output logic [CW-1:0] sweep_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_UP       = 3'd1;
    localparam logic [2:0] S_DWELL_HI = 3'd2;
    localparam logic [2:0] S_DOWN     = 3'd3;
    localparam logic [2:0] S_DWELL_LO = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]    r_state;
    logic [N-1:0]  r_lo;
    logic [N-1:0]  r_hi;
    logic [CW-1:0] r_cycles;
    logic [CW-1:0] r_dwell;
    logic [CW-1:0] r_dwell_cnt;
    logic [N-1:0]  r_count;
    logic [CW-1:0] r_sweep_cnt;
    logic          r_up;
    logic          r_err;

    logic          w_busy;
    logic          w_start_ok;
    logic          w_abort;
    logic [N-1:0]  w_count_inc;
    logic [N-1:0]  w_count_dec;
    logic [CW-1:0] w_sweep_inc;

    // The counter only moves between latched bounds with lo < hi, so the
    // incremented/decremented values never wrap when they are used.
    assign w_count_inc = r_count + 1'b1;
    assign w_count_dec = r_count - 1'b1;
    assign w_sweep_inc = r_sweep_cnt + 1'b1;
    assign w_start_ok  = (lo < hi) && (cycles != '0);
    assign w_busy      = (r_state == S_UP) || (r_state == S_DWELL_HI) ||
                         (r_state == S_DOWN) || (r_state == S_DWELL_LO);

`ifdef SWEEP_ABORT_EN
    assign w_abort = abort && w_busy;
`else
    assign w_abort = 1'b0;
`endif

    // Sweep sequencer: command latch, counter datapath and state transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lo        <= '0;
            r_hi        <= '0;
            r_cycles    <= '0;
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
            r_count     <= '0;
            r_sweep_cnt <= '0;
            r_up        <= 1'b1;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (w_abort) begin
                // Abort beats this cycle's count update; count/sweep_cnt hold.
                r_state <= S_IDLE;
                r_up    <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_start_ok) begin
                                r_lo        <= lo;
                                r_hi        <= hi;
                                r_cycles    <= cycles;
                                r_dwell     <= dwell;
                                r_count     <= lo;
                                r_sweep_cnt <= '0;
                                r_up        <= 1'b1;
                                r_state     <= S_UP;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    S_UP: begin
                        r_count <= w_count_inc;
                        if (w_count_inc == r_hi) begin
                            r_up <= 1'b0;
                            if (r_dwell != '0) begin
                                r_dwell_cnt <= r_dwell;
                                r_state     <= S_DWELL_HI;
                            end else begin
                                r_state <= S_DOWN;
                            end
                        end
                    end
                    S_DWELL_HI: begin
                        // Entry loaded the full dwell; leaving on 1 gives exactly dwell cycles.
                        r_dwell_cnt <= r_dwell_cnt - 1'b1;
                        if (r_dwell_cnt == CW'(1)) begin
                            r_state <= S_DOWN;
                        end
                    end
                    S_DOWN: begin
                        r_count <= w_count_dec;
                        if (w_count_dec == r_lo) begin
                            r_sweep_cnt <= w_sweep_inc;
                            if (w_sweep_inc == r_cycles) begin
                                r_state <= S_DONE;
                            end else if (r_dwell != '0) begin
                                r_dwell_cnt <= r_dwell;
                                r_state     <= S_DWELL_LO;
                            end else begin
                                r_up    <= 1'b1;
                                r_state <= S_UP;
                            end
                        end
                    end
                    S_DWELL_LO: begin
                        r_dwell_cnt <= r_dwell_cnt - 1'b1;
                        if (r_dwell_cnt == CW'(1)) begin
                            r_up    <= 1'b1;
                            r_state <= S_UP;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);
    assign err        = r_err;
    assign up_or_down = r_up;
    assign count      = r_count;
    assign sweep_cnt  = r_sweep_cnt;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// tb_updown_sweep_ctrl: directed-vector bench for updown_sweep_ctrl (N=4, CW=8).
// Expected count sequences are hand-computed tables; outputs are sampled 1ns
// after each rising edge. Abort vectors run only when SWEEP_ABORT_EN is defined.
module tb_updown_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
`ifdef SWEEP_ABORT_EN
    logic       abort;
`endif
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] cycles;
    logic [7:0] dwell;
    logic       busy;
    logic       done;
    logic       err;
    logic       up_or_down;
    logic [3:0] count;
    logic [7:0] sweep_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    updown_sweep_ctrl #(.N(4), .CW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef SWEEP_ABORT_EN
        .abort      (abort),
`endif
        .lo         (lo),
        .hi         (hi),
        .cycles     (cycles),
        .dwell      (dwell),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .up_or_down (up_or_down),
        .count      (count),
        .sweep_cnt  (sweep_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when it misses.
    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a command and strobe start across one edge; returns just after it.
    task automatic issue(input int l, input int h, input int c, input int d);
        lo     = 4'(l);
        hi     = 4'(h);
        cycles = 8'(c);
        dwell  = 8'(d);
        start  = 1'b1;
        step();
        start  = 1'b0;
        $display("cmd lo=%0d hi=%0d cycles=%0d dwell=%0d -> count=%0d busy=%0d err=%0d",
                 l, h, c, d, count, busy, err);
    endtask

    int t1_cnt [7]  = '{2, 3, 4, 5, 4, 3, 2};
    int t2_cnt [15] = '{1, 2, 3, 3, 3, 2, 1, 1, 1, 2, 3, 3, 3, 2, 1};
    int t5_cnt [4]  = '{7, 8, 8, 7};
    int done_seen;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
`ifdef SWEEP_ABORT_EN
        abort  = 1'b0;
`endif
        lo     = '0;
        hi     = '0;
        cycles = '0;
        dwell  = '0;
        #1;
        step();
        step();
        check("rst_count", int'(count), 0);
        check("rst_up", int'(up_or_down), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        check("rst_sweep", int'(sweep_cnt), 0);
        rst = 1'b0;
        step();

        // Test 1: lo=2 hi=5 cycles=1 dwell=0; done 2*3 edges after the start edge.
        issue(2, 5, 1, 0);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            check($sformatf("t1_count[%0d]", i), int'(count), t1_cnt[i]);
            if (i < 6) begin
                check($sformatf("t1_up[%0d]", i), int'(up_or_down), (i < 3) ? 1 : 0);
                check($sformatf("t1_busy[%0d]", i), int'(busy), 1);
                check($sformatf("t1_done[%0d]", i), int'(done), 0);
            end
        end
        check("t1_done_pulse", int'(done), 1);
        check("t1_done_busy", int'(busy), 0);
        check("t1_sweep", int'(sweep_cnt), 1);
        step();
        check("t1_done_drop", int'(done), 0);
        check("t1_idle_count", int'(count), 2);
        check("t1_idle_sweep", int'(sweep_cnt), 1);
        check("t1_idle_busy", int'(busy), 0);

        // Test 2: lo=1 hi=3 dwell=2 cycles=2, no low dwell after the last trip.
        step();
        issue(1, 3, 2, 2);
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (i > 0) step();
            check($sformatf("t2_count[%0d]", i), int'(count), t2_cnt[i]);
            done_seen += int'(done);
            if (i == 6) check("t2_sweep_1", int'(sweep_cnt), 1);
            if (i < 14) check($sformatf("t2_busy[%0d]", i), int'(busy), 1);
        end
        check("t2_done_at_end", int'(done), 1);
        check("t2_sweep_2", int'(sweep_cnt), 2);
        step();
        done_seen += int'(done);
        check("t2_done_pulses", done_seen, 1);

        // Test 3: rejected commands pulse err and leave state alone.
        issue(5, 5, 1, 0);
        check("t3a_err", int'(err), 1);
        check("t3a_busy", int'(busy), 0);
        check("t3a_count", int'(count), 1);
        check("t3a_sweep", int'(sweep_cnt), 2);
        step();
        check("t3a_err_drop", int'(err), 0);
        issue(3, 7, 0, 0);
        check("t3b_err", int'(err), 1);
        check("t3b_busy", int'(busy), 0);
        check("t3b_count", int'(count), 1);
        step();
        check("t3b_err_drop", int'(err), 0);

        // Test 4: full range 0..15, no wrap; bound inputs scrambled while busy.
        issue(0, 15, 1, 0);
        for (int i = 0; i < 31; i++) begin
            if (i > 0) step();
            if (i == 3) begin
                lo = 4'd9;
                hi = 4'd4;
            end
            check($sformatf("t4_count[%0d]", i), int'(count), (i <= 15) ? i : 30 - i);
            if (i < 30) check($sformatf("t4_done[%0d]", i), int'(done), 0);
        end
        check("t4_done", int'(done), 1);
        step();

        // Test 5: single-step legs (hi-lo=1) with dwell=1.
        issue(7, 8, 1, 1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            check($sformatf("t5_count[%0d]", i), int'(count), t5_cnt[i]);
        end
        check("t5_done", int'(done), 1);
        step();

        // Test 6: start ignored mid-sweep, then reset wins.
        issue(2, 8, 1, 0);
        step();
        step();
        check("t6_count4", int'(count), 4);
        lo    = 4'd0;
        hi    = 4'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_ign_count", int'(count), 5);
        check("t6_ign_err", int'(err), 0);
        check("t6_ign_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rst_count", int'(count), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_sweep", int'(sweep_cnt), 0);
        check("t6_rst_up", int'(up_or_down), 1);
        done_seen = int'(done);
        for (int i = 0; i < 5; i++) begin
            step();
            done_seen += int'(done) + int'(busy);
        end
        check("t6_no_done", done_seen, 0);

`ifdef SWEEP_ABORT_EN
        // Test 7: abort at count=4 on the DOWN leg, then a normal command.
        issue(2, 6, 1, 0);
        for (int i = 1; i <= 6; i++) step();
        check("t7_pre_count", int'(count), 4);
        check("t7_pre_up", int'(up_or_down), 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t7_ab_busy", int'(busy), 0);
        check("t7_ab_count", int'(count), 4);
        check("t7_ab_up", int'(up_or_down), 1);
        check("t7_ab_done", int'(done), 0);
        step();
        check("t7_ab_done2", int'(done), 0);
        issue(1, 2, 1, 0);
        check("t7_re_count", int'(count), 1);
        check("t7_re_busy", int'(busy), 1);
        step();
        check("t7_re_count2", int'(count), 2);
        step();
        check("t7_re_count3", int'(count), 1);
        check("t7_re_done", int'(done), 1);
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
